// File: rtl/beat_mem_responder.sv
// Memory-side endpoint of the 16-bit beat bus: a synchronous SRAM that absorbs
// write bursts and returns read bursts after a fixed latency, with optional bubbles.
module beat_mem_responder #(
    parameter int LG_DEPTH = 12,
    parameter int D_WIDTH  = 16,
    parameter int N_BEATS  = 8,
    parameter int RD_LAT   = 2,
    parameter int M_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_is_write,
    input  logic [M_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               wr_valid,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    input  logic               stall_en,
    input  logic [N_BEATS-1:0] stall_mask,
    output logic               busy,
    output logic               err
);

    localparam int DEPTH = 1 << LG_DEPTH;
    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD} state_t;

    state_t              state_q;
    logic [LG_DEPTH-1:0] idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LAT_W-1:0]    lat_q;
    logic                bubble_done_q;
    logic                rd_valid_q;
    logic [D_WIDTH-1:0]  rd_data_q;
    logic                busy_q;
    logic                err_q;
    logic [D_WIDTH-1:0]  mem_q [DEPTH];

    logic [LG_DEPTH-1:0] word_d;
    logic                req_legal_d;
    logic                wr_fire_d;
    logic                rd_bubble_d;
    logic                rd_fire_d;

    // Beat addresses wrap modulo the SRAM depth.
    assign word_d      = idx_q + LG_DEPTH'(cnt_q);
    assign req_legal_d = ~req_addr[0] && ((req_addr >> (LG_DEPTH + 1)) == '0);
    assign wr_fire_d   = (state_q == WR) && wr_valid;
    assign rd_bubble_d = (state_q == RD) && stall_en && stall_mask[cnt_q] && !bubble_done_q;
    assign rd_fire_d   = (state_q == RD) && !rd_bubble_d;

    always_ff @(posedge clk) begin
        if (wr_fire_d) begin
            mem_q[word_d] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            lat_q         <= '0;
            bubble_done_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            if (rd_fire_d) begin
                rd_data_q <= mem_q[word_d];
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_legal_d) begin
                            err_q <= 1'b1;
                        end else begin
                            idx_q         <= req_addr[LG_DEPTH:1];
                            cnt_q         <= '0;
                            bubble_done_q <= 1'b0;
                            busy_q        <= 1'b1;
                            if (req_is_write) begin
                                state_q <= WR;
                            end else if (RD_LAT == 0) begin
                                state_q <= RD;
                            end else begin
                                state_q <= RD_WAIT;
                                lat_q   <= LAT_W'(RD_LAT);
                            end
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    lat_q <= lat_q - 1'b1;
                    if (lat_q == LAT_W'(1)) begin
                        state_q <= RD;
                    end
                end
                RD: begin
                    // A bubble is spent once per beat; the flag clears when the beat issues.
                    if (rd_bubble_d) begin
                        bubble_done_q <= 1'b1;
                    end else begin
                        rd_valid_q    <= 1'b1;
                        bubble_done_q <= 1'b0;
                        cnt_q         <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_beat_mem_responder.sv
// Directed bench for beat_mem_responder: bursts, bubbles, wrap, rejects, gaps, reset abort.
module tb_beat_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_is_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        stall_en = 1'b0;
    logic [7:0]  stall_mask = '0;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] beat_d [$];
    int          beat_c [$];
    logic [15:0] exp_d [8];
    int          exp_off [8];

    beat_mem_responder #(
        .LG_DEPTH(12), .D_WIDTH(16), .N_BEATS(8), .RD_LAT(2), .M_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_write(req_is_write),
        .req_addr(req_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .stall_en(stall_en),
        .stall_mask(stall_mask), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_valid) begin
            beat_d.push_back(rd_data);
            beat_c.push_back(cyc);
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle number of the accepting edge.
    task automatic send_req(input logic w, input logic [15:0] a, output int t);
        req_valid    = 1'b1;
        req_is_write = w;
        req_addr     = a;
        tick();
        t = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wr_burst(input string tag, input logic [15:0] a, input logic [15:0] d0,
                            input logic [15:0] pat);
        int t;
        int n;
        logic v;
        n = 0;
        send_req(1'b1, a, t);
        for (int i = 0; i < 48 && n < 8; i++) begin
            v        = pat[i % 16];
            wr_valid = v;
            wr_data  = v ? d0 + 16'(n) : 16'hBAD0;
            tick();
            if (v) begin
                n++;
                check_vec($sformatf("%s_busy%0d", tag, n), {31'b0, busy}, {31'b0, (n < 8)});
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd_burst(input string tag, input logic [15:0] a);
        int t;
        beat_d.delete();
        beat_c.delete();
        send_req(1'b0, a, t);
        check_vec({tag, "_busy"}, {31'b0, busy}, 32'd1);
        for (int i = 0; i < 40 && beat_d.size() < 8; i++) tick();
        check_vec({tag, "_cnt"}, beat_d.size(), 32'd8);
        for (int k = 0; k < 8 && k < beat_d.size(); k++) begin
            check_vec($sformatf("%s_d%0d", tag, k), {16'b0, beat_d[k]}, {16'b0, exp_d[k]});
            check_vec($sformatf("%s_t%0d", tag, k), beat_c[k] - t, exp_off[k]);
        end
        check_vec({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic reject(input string tag, input logic [15:0] a);
        int t;
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        send_req(1'b1, a, t);
        check_vec({tag, "_err1"}, {31'b0, err}, 32'd1);
        check_vec({tag, "_busy1"}, {31'b0, busy}, 32'd0);
        tick();
        check_vec({tag, "_err2"}, {31'b0, err}, 32'd0);
        check_vec({tag, "_busy2"}, {31'b0, busy}, 32'd0);
        wr_valid = 1'b0;
    endtask

    task automatic exp_linear(input logic [15:0] d0);
        for (int k = 0; k < 8; k++) begin
            exp_d[k]   = d0 + 16'(k);
            exp_off[k] = 3 + k;
        end
    endtask

    initial begin
        int t;
        #1;
        tick();
        check_vec("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check_vec("rst_rd_data", {16'b0, rd_data}, 32'd0);
        check_vec("rst_busy", {31'b0, busy}, 32'd0);
        check_vec("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b1;
        tick();

        // Plain write then read; mask set but disabled.
        wr_burst("t1_wr", 16'h0020, 16'h1000, 16'hFFFF);
        stall_mask = 8'hFF;
        exp_linear(16'h1000);
        rd_burst("t1_rd", 16'h0020);

        // Bubbles before beats 0 and 2.
        stall_en   = 1'b1;
        stall_mask = 8'b0000_0101;
        exp_off    = '{4, 5, 7, 8, 9, 10, 11, 12};
        rd_burst("t2_rd", 16'h0020);
        stall_en   = 1'b0;
        stall_mask = '0;

        // Wrap: pre-fill words 0..7, then a burst from idx 4094 wraps onto words 0..5.
        wr_burst("t3_pre", 16'h0000, 16'h5000, 16'hFFFF);
        wr_burst("t3_wr", 16'h1FFC, 16'h3000, 16'hFFFF);
        exp_linear(16'h3000);
        rd_burst("t3_rd", 16'h1FFC);
        exp_d = '{16'h3002, 16'h3003, 16'h3004, 16'h3005, 16'h3006, 16'h3007, 16'h5006, 16'h5007};
        rd_burst("t3_rd0", 16'h0000);

        // Rejected addresses must not touch the SRAM.
        reject("t4_odd", 16'h0021);
        reject("t4_high", 16'h2000);
        exp_linear(16'h1000);
        rd_burst("t4_rd20", 16'h0020);
        exp_d = '{16'h3002, 16'h3003, 16'h3004, 16'h3005, 16'h3006, 16'h3007, 16'h5006, 16'h5007};
        rd_burst("t4_rd0", 16'h0000);

        // Gapped write burst, then a stray wr_valid in IDLE.
        wr_burst("t5_wr", 16'h0100, 16'h4000, 16'h1B69);
        wr_valid = 1'b1;
        wr_data  = 16'hEEEE;
        tick();
        wr_valid = 1'b0;
        check_vec("t5_stray_busy", {31'b0, busy}, 32'd0);
        exp_linear(16'h4000);
        rd_burst("t5_rd", 16'h0100);

        // Reset during read beat 3.
        beat_d.delete();
        beat_c.delete();
        send_req(1'b0, 16'h0020, t);
        for (int i = 0; i < 20 && cyc < t + 6; i++) tick();
        check_vec("t6_beat3_vld", {31'b0, rd_valid}, 32'd1);
        check_vec("t6_beat3_dat", {16'b0, rd_data}, 32'h1003);
        reset = 1'b0;
        #1;
        check_vec("t6_async_vld", {31'b0, rd_valid}, 32'd0);
        check_vec("t6_async_busy", {31'b0, busy}, 32'd0);
        check_vec("t6_async_dat", {16'b0, rd_data}, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (12) tick();
        check_vec("t6_beats_seen", beat_d.size(), 32'd3);
        check_vec("t6_post_busy", {31'b0, busy}, 32'd0);
        exp_linear(16'h1000);
        rd_burst("t6_rd", 16'h0020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
